sdram_axi_burst_master: RTL and testbench

- Command-driven AXI4 burst initiator that drives the slave port of the SDRAM AXI controller: one command in, one AXI read or write burst out.
- Used by the SDRAM test and DMA path to issue INCR bursts.
- Streams write data from, and read data to, simple valid/ready ports.
- Reports a per-command completion pulse with the worst response seen and a protocol-error flag.

---
 rtl/sdram_axi_pkg.sv | 33 +++
 rtl/sdram_axi_burst_master.sv | 198 +++++++++++++++++++
 tb/tb_sdram_axi_burst_master.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_axi_pkg.sv
// Shared definitions for the SDRAM AXI burst master.
//   state_e     : burst master FSM state encoding
//   AXI_*       : AXI4 burst-type and response codes
//   crosses_4k  : true when an INCR burst of 32-bit beats would run past a
//                 4 KB boundary (AXI forbids bursts that cross one)
package sdram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REJECT,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // The end address is computed in 13 bits so that an end landing exactly on
  // 4096 (burst fills the page) is legal and anything beyond is not.
  function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                      input logic [7:0]  len);
    logic [12:0] end_addr;
    end_addr = {1'b0, addr_lo} + {3'b000, len, 2'b00} + 13'd4;
    return end_addr > 13'd4096;
  endfunction

endpackage

// File: rtl/sdram_axi_burst_master.sv
// Command-driven AXI4 INCR burst initiator for the SDRAM AXI controller.
// One accepted command produces exactly one AXI read or write burst.
// Ports:
//   ACLK, ARSTN                  clock, async active-low reset
//   cmd_*                        command request (write/read, address, len)
//   wr_valid_i/wr_ready_o/...    write-data stream, passed to the W channel
//   rd_valid_o/rd_ready_i/...    read-data stream, fed from the R channel
//   done_o/done_resp_o/done_err_o completion pulse, worst response, error flag
//   M00_AXI_*                    AXI4 master (AW, W, B, AR, R channels)
module sdram_axi_burst_master
  import sdram_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARSTN,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [3:0]            wr_strb_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  done_o,
  output logic [1:0]            done_resp_o,
  output logic                  done_err_o,
  output logic                  M00_AXI_awvalid,
  input  logic                  M00_AXI_awready,
  output logic [ADDR_WIDTH-1:0] M00_AXI_awaddr,
  output logic [7:0]            M00_AXI_awlen,
  output logic [1:0]            M00_AXI_awburst,
  output logic                  M00_AXI_wvalid,
  input  logic                  M00_AXI_wready,
  output logic [DATA_WIDTH-1:0] M00_AXI_wdata,
  output logic [3:0]            M00_AXI_wstrb,
  output logic                  M00_AXI_wlast,
  input  logic                  M00_AXI_bvalid,
  output logic                  M00_AXI_bready,
  input  logic [1:0]            M00_AXI_bresp,
  output logic                  M00_AXI_arvalid,
  input  logic                  M00_AXI_arready,
  output logic [ADDR_WIDTH-1:0] M00_AXI_araddr,
  output logic [7:0]            M00_AXI_arlen,
  output logic [1:0]            M00_AXI_arburst,
  input  logic                  M00_AXI_rvalid,
  output logic                  M00_AXI_rready,
  input  logic [DATA_WIDTH-1:0] M00_AXI_rdata,
  input  logic [1:0]            M00_AXI_rresp,
  input  logic                  M00_AXI_rlast
);

  state_e                state_q, state_d;
  logic                  alive_q;     // low during reset so cmd_ready_o stays 0
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [1:0]            resp_q;
  logic                  err_q;
  logic [1:0]            done_resp_q;
  logic                  done_err_q;
  logic                  last_beat;

  assign last_beat       = (beat_q == len_q);
  assign M00_AXI_awaddr  = addr_q;
  assign M00_AXI_awlen   = len_q;
  assign M00_AXI_awburst = AXI_BURST_INCR;
  assign M00_AXI_araddr  = addr_q;
  assign M00_AXI_arlen   = len_q;
  assign M00_AXI_arburst = AXI_BURST_INCR;

  // Show the fresh result in the same cycle as the done_o pulse, then hold it.
  assign done_resp_o = (state_q == ST_DONE) ? resp_q : done_resp_q;
  assign done_err_o  = (state_q == ST_DONE) ? err_q  : done_err_q;

  // NOTE: every output and state_d gets a default before the case statement,
  // so no path through this block leaves a value unassigned (no latches).
  always_comb begin
    state_d         = state_q;
    cmd_ready_o     = 1'b0;
    wr_ready_o      = 1'b0;
    rd_valid_o      = 1'b0;
    rd_data_o       = '0;
    rd_last_o       = 1'b0;
    done_o          = 1'b0;
    M00_AXI_awvalid = 1'b0;
    M00_AXI_wvalid  = 1'b0;
    M00_AXI_wdata   = '0;
    M00_AXI_wstrb   = '0;
    M00_AXI_wlast   = 1'b0;
    M00_AXI_bready  = 1'b0;
    M00_AXI_arvalid = 1'b0;
    M00_AXI_rready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = alive_q;
        if (cmd_valid_i && alive_q) begin
          if (cmd_addr_i[1:0] != 2'b00 || crosses_4k(cmd_addr_i[11:0], cmd_len_i))
            state_d = ST_REJECT;
          else
            state_d = cmd_write_i ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_REJECT: state_d = ST_DONE;
      ST_WR_ADDR: begin
        M00_AXI_awvalid = 1'b1;
        if (M00_AXI_awready) state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        // Stream and W channel are wired straight through; valid never
        // depends on an AXI ready, only the stream-side ready does.
        M00_AXI_wvalid = wr_valid_i;
        wr_ready_o     = M00_AXI_wready;
        M00_AXI_wdata  = wr_data_i;
        M00_AXI_wstrb  = wr_strb_i;
        M00_AXI_wlast  = last_beat;
        if (wr_valid_i && M00_AXI_wready && last_beat) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        M00_AXI_bready = 1'b1;
        if (M00_AXI_bvalid) state_d = ST_DONE;
      end
      ST_RD_ADDR: begin
        M00_AXI_arvalid = 1'b1;
        if (M00_AXI_arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        M00_AXI_rready = rd_ready_i;
        rd_valid_o     = M00_AXI_rvalid;
        rd_data_o      = M00_AXI_rdata;
        rd_last_o      = M00_AXI_rlast;
        // The slave's rlast ends the burst even when the count disagrees.
        if (M00_AXI_rvalid && rd_ready_i && M00_AXI_rlast) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state_q <= ST_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      resp_q      <= AXI_RESP_OKAY;
      err_q       <= 1'b0;
      done_resp_q <= AXI_RESP_OKAY;
      done_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid_i && alive_q) begin
          addr_q <= cmd_addr_i;
          len_q  <= cmd_len_i;
          resp_q <= AXI_RESP_OKAY;
          err_q  <= 1'b0;
        end
        ST_REJECT:  err_q <= 1'b1;
        ST_WR_ADDR: if (M00_AXI_awready) beat_q <= '0;
        ST_WR_DATA: if (wr_valid_i && M00_AXI_wready) beat_q <= beat_q + 8'd1;
        ST_WR_RESP: if (M00_AXI_bvalid) resp_q <= M00_AXI_bresp;
        ST_RD_ADDR: if (M00_AXI_arready) beat_q <= '0;
        ST_RD_DATA: if (M00_AXI_rvalid && rd_ready_i) begin
          beat_q <= beat_q + 8'd1;
          if (M00_AXI_rresp > resp_q) resp_q <= M00_AXI_rresp;
          // Early rlast or missing rlast on the final counted beat.
          if (M00_AXI_rlast != last_beat) err_q <= 1'b1;
        end
        ST_DONE: begin
          done_resp_q <= resp_q;
          done_err_q  <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_axi_burst_master.sv
// Self-checking bench for sdram_axi_burst_master: randomized AXI slave,
// write-stream source and read-stream sink, checked against a burst-level
// reference model (expected beats, responses and reject rules).
module tb_sdram_axi_burst_master;

  logic        ACLK = 1'b0;
  logic        ARSTN = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic        wr_valid_i = 1'b0, wr_ready_o;
  logic [31:0] wr_data_i = '0;
  logic [3:0]  wr_strb_i = '0;
  logic        rd_valid_o, rd_ready_i = 1'b0, rd_last_o;
  logic [31:0] rd_data_o;
  logic        done_o, done_err_o;
  logic [1:0]  done_resp_o;
  logic        M00_AXI_awvalid, M00_AXI_awready = 1'b0;
  logic [31:0] M00_AXI_awaddr;
  logic [7:0]  M00_AXI_awlen;
  logic [1:0]  M00_AXI_awburst;
  logic        M00_AXI_wvalid, M00_AXI_wready = 1'b0, M00_AXI_wlast;
  logic [31:0] M00_AXI_wdata;
  logic [3:0]  M00_AXI_wstrb;
  logic        M00_AXI_bvalid = 1'b0, M00_AXI_bready;
  logic [1:0]  M00_AXI_bresp = '0;
  logic        M00_AXI_arvalid, M00_AXI_arready = 1'b0;
  logic [31:0] M00_AXI_araddr;
  logic [7:0]  M00_AXI_arlen;
  logic [1:0]  M00_AXI_arburst;
  logic        M00_AXI_rvalid = 1'b0, M00_AXI_rready, M00_AXI_rlast = 1'b0;
  logic [31:0] M00_AXI_rdata = '0;
  logic [1:0]  M00_AXI_rresp = '0;

  always #5 ACLK = ~ACLK;

  sdram_axi_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARSTN(ARSTN),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .wr_strb_i(wr_strb_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .rd_last_o(rd_last_o),
    .done_o(done_o), .done_resp_o(done_resp_o), .done_err_o(done_err_o),
    .M00_AXI_awvalid(M00_AXI_awvalid), .M00_AXI_awready(M00_AXI_awready),
    .M00_AXI_awaddr(M00_AXI_awaddr), .M00_AXI_awlen(M00_AXI_awlen),
    .M00_AXI_awburst(M00_AXI_awburst),
    .M00_AXI_wvalid(M00_AXI_wvalid), .M00_AXI_wready(M00_AXI_wready),
    .M00_AXI_wdata(M00_AXI_wdata), .M00_AXI_wstrb(M00_AXI_wstrb),
    .M00_AXI_wlast(M00_AXI_wlast),
    .M00_AXI_bvalid(M00_AXI_bvalid), .M00_AXI_bready(M00_AXI_bready),
    .M00_AXI_bresp(M00_AXI_bresp),
    .M00_AXI_arvalid(M00_AXI_arvalid), .M00_AXI_arready(M00_AXI_arready),
    .M00_AXI_araddr(M00_AXI_araddr), .M00_AXI_arlen(M00_AXI_arlen),
    .M00_AXI_arburst(M00_AXI_arburst),
    .M00_AXI_rvalid(M00_AXI_rvalid), .M00_AXI_rready(M00_AXI_rready),
    .M00_AXI_rdata(M00_AXI_rdata), .M00_AXI_rresp(M00_AXI_rresp),
    .M00_AXI_rlast(M00_AXI_rlast)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] burst; } addr_rec_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } beat_t;

  int n_checks = 0, n_fail = 0;

  // Environment knobs (percent stall probability, sink mode, slave responses)
  int aw_stall = 0, w_stall = 0, ar_stall = 0, src_stall = 0;
  int rd_mode = 0;              // 0 always ready, 1 toggle, 2 random
  int r_last_cfg = -1;          // beat index carrying rlast, -1 = arlen
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] r_data_cfg [0:299];
  logic [1:0]  r_resp_cfg [0:299];

  // Observations
  addr_rec_t aw_log[$], ar_log[$];
  beat_t     w_log[$], rd_log[$], wr_q[$];
  int aw_valid_cycles = 0, ar_valid_cycles = 0, proto_viol = 0;
  int done_count = 0, done_run = 0, done_run_max = 0;

  // AXI slave: drives on the falling edge, logs the transfers that the
  // following rising edge will complete.
  initial begin
    int b_owed, r_idx, r_cnt, r_last_idx;
    bit r_active, aw_pend, ar_pend, aw_open;
    logic [31:0] aw_addr_prev, ar_addr_prev;
    logic [7:0]  aw_len_prev, ar_len_prev;
    b_owed = 0; r_idx = 0; r_cnt = 0; r_last_idx = 0;
    r_active = 0; aw_pend = 0; ar_pend = 0; aw_open = 0;
    aw_addr_prev = '0; ar_addr_prev = '0; aw_len_prev = '0; ar_len_prev = '0;
    forever begin
      @(negedge ACLK);
      if (!ARSTN) begin
        b_owed = 0; r_active = 0; aw_pend = 0; ar_pend = 0; aw_open = 0;
        M00_AXI_awready = 0; M00_AXI_wready = 0; M00_AXI_arready = 0;
        M00_AXI_bvalid = 0; M00_AXI_rvalid = 0; M00_AXI_rlast = 0;
        continue;
      end
      M00_AXI_awready = ($urandom_range(99) >= aw_stall);
      M00_AXI_wready  = ($urandom_range(99) >= w_stall);
      M00_AXI_arready = ($urandom_range(99) >= ar_stall);
      M00_AXI_bvalid  = (b_owed > 0);
      M00_AXI_bresp   = bresp_cfg;
      M00_AXI_rvalid  = r_active && (r_idx < r_cnt);
      M00_AXI_rdata   = M00_AXI_rvalid ? r_data_cfg[r_idx] : '0;
      M00_AXI_rresp   = M00_AXI_rvalid ? r_resp_cfg[r_idx] : 2'b00;
      M00_AXI_rlast   = M00_AXI_rvalid && (r_idx == r_last_idx);
      #1;
      if (!ARSTN) continue;
      if (M00_AXI_awvalid) begin
        aw_valid_cycles++;
        if (aw_pend && (M00_AXI_awaddr != aw_addr_prev || M00_AXI_awlen != aw_len_prev))
          proto_viol++;
      end else if (aw_pend) proto_viol++;
      aw_pend = M00_AXI_awvalid && !M00_AXI_awready;
      aw_addr_prev = M00_AXI_awaddr; aw_len_prev = M00_AXI_awlen;
      if (M00_AXI_awvalid && M00_AXI_awready) begin
        aw_log.push_back(addr_rec_t'{M00_AXI_awaddr, M00_AXI_awlen, M00_AXI_awburst});
        aw_open = 1;
      end
      if (M00_AXI_wvalid && !aw_open) proto_viol++;
      if (M00_AXI_wvalid && M00_AXI_wready) begin
        w_log.push_back(beat_t'{M00_AXI_wdata, M00_AXI_wstrb, M00_AXI_wlast});
        if (M00_AXI_wlast) begin aw_open = 0; b_owed++; end
      end
      if (M00_AXI_bvalid && M00_AXI_bready) b_owed--;
      if (M00_AXI_arvalid) begin
        ar_valid_cycles++;
        if (ar_pend && (M00_AXI_araddr != ar_addr_prev || M00_AXI_arlen != ar_len_prev))
          proto_viol++;
      end else if (ar_pend) proto_viol++;
      ar_pend = M00_AXI_arvalid && !M00_AXI_arready;
      ar_addr_prev = M00_AXI_araddr; ar_len_prev = M00_AXI_arlen;
      if (M00_AXI_arvalid && M00_AXI_arready) begin
        ar_log.push_back(addr_rec_t'{M00_AXI_araddr, M00_AXI_arlen, M00_AXI_arburst});
        r_active = 1; r_idx = 0;
        r_last_idx = (r_last_cfg < 0) ? int'(M00_AXI_arlen) : r_last_cfg;
        r_cnt = r_last_idx + 1;
      end
      if (M00_AXI_rvalid && M00_AXI_rready) begin
        r_idx++;
        if (r_idx >= r_cnt) r_active = 0;
      end
    end
  end

  // Write-data stream source
  initial forever begin
    @(negedge ACLK);
    if (!ARSTN) begin wr_q.delete(); wr_valid_i = 0; continue; end
    if (wr_q.size() > 0 && $urandom_range(99) >= src_stall) begin
      wr_valid_i = 1; wr_data_i = wr_q[0].data; wr_strb_i = wr_q[0].strb;
    end else begin
      wr_valid_i = 0; wr_data_i = $urandom; wr_strb_i = '0;
    end
    #1;
    if (ARSTN && wr_valid_i && wr_ready_o) void'(wr_q.pop_front());
  end

  // Read-data stream sink
  initial begin
    bit tog;
    tog = 0;
    forever begin
      @(negedge ACLK);
      tog = ~tog;
      case (rd_mode)
        0:       rd_ready_i = 1'b1;
        1:       rd_ready_i = tog;
        default: rd_ready_i = ($urandom_range(1) == 1);
      endcase
      #1;
      if (ARSTN && rd_valid_o && rd_ready_i)
        rd_log.push_back(beat_t'{rd_data_o, 4'hF, rd_last_o});
    end
  end

  // Completion monitor
  initial forever begin
    @(negedge ACLK);
    #1;
    if (done_o) begin
      done_count++; done_run++;
      if (done_run > done_run_max) done_run_max = done_run;
    end else done_run = 0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_reject(input logic [31:0] addr, input logic [7:0] len);
    int page_off, bytes;
    page_off = int'(addr % 4096);
    bytes    = (int'(len) + 1) * 4;
    return (addr % 4 != 0) || (page_off + bytes > 4096);
  endfunction

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len);
    int guard;
    guard = 0;
    @(negedge ACLK);
    cmd_valid_i = 1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = len;
    #1;
    while (!cmd_ready_o && guard < 1000) begin @(negedge ACLK); #1; guard++; end
    @(negedge ACLK);
    cmd_valid_i = 0;
  endtask

  task automatic wait_done(input int start, input int budget, output bit timed_out);
    int c;
    c = 0;
    while (done_count == start && c < budget) begin @(negedge ACLK); #1; c++; end
    timed_out = (done_count == start);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({cmd_ready_o, wr_ready_o, rd_valid_o, rd_last_o, done_o, M00_AXI_awvalid,
         M00_AXI_wvalid, M00_AXI_wlast, M00_AXI_bready, M00_AXI_arvalid,
         M00_AXI_rready} !== 11'b0) begin
      n_fail++; $display("FAIL reset_ctrl: outputs not all zero during reset");
    end
    n_checks++;
    if ({M00_AXI_awaddr, M00_AXI_awlen, M00_AXI_araddr, done_resp_o, done_err_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: awaddr=%h awlen=%0d resp=%0d err=%b expected 0",
                         M00_AXI_awaddr, M00_AXI_awlen, done_resp_o, done_err_o);
    end
    repeat (2) @(negedge ACLK);
    ARSTN = 1;
    repeat (2) @(negedge ACLK);
    #1;
    n_checks++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL idle_ready: cmd_ready_o=%b expected 1", cmd_ready_o);
    end
  endtask

  task automatic test_write_burst(input logic [31:0] addr, input logic [7:0] len,
                                  input bit pattern, input string tag);
    beat_t exp[$];
    beat_t b;
    int bad, first_bad, start;
    bit to;
    aw_log.delete(); w_log.delete(); proto_viol = 0; done_run_max = 0;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = pattern ? 32'(32'h11 * (i + 1)) : $urandom;
      b.strb = pattern ? 4'hF : 4'($urandom_range(15));
      b.last = (i == int'(len));
      exp.push_back(b); wr_q.push_back(b);
    end
    start = done_count;
    issue_cmd(1'b1, addr, len);
    wait_done(start, int'(len) * 40 + 500, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL %s_timeout: no done_o", tag); end
    n_checks++;
    if (aw_log.size() != 1) begin
      n_fail++; $display("FAIL %s_aw_count: %0d AW transfers, expected 1", tag, aw_log.size());
    end else if (aw_log[0].addr !== addr || aw_log[0].len !== len || aw_log[0].burst !== 2'b01) begin
      n_fail++; $display("FAIL %s_aw: addr=%h len=%0d burst=%0d expected %h %0d 1",
                         tag, aw_log[0].addr, aw_log[0].len, aw_log[0].burst, addr, len);
    end
    n_checks++;
    if (w_log.size() != exp.size()) begin
      n_fail++; $display("FAIL %s_w_count: %0d W beats, expected %0d", tag, w_log.size(), exp.size());
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < exp.size() && i < w_log.size(); i++)
      if (w_log[i].data !== exp[i].data || w_log[i].strb !== exp[i].strb ||
          w_log[i].last !== exp[i].last) begin
        bad++; if (first_bad < 0) first_bad = i;
      end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_w_beats: %0d bad beats, first %0d got %h/%h/%b expected %h/%h/%b", tag,
               bad, first_bad, w_log[first_bad].data, w_log[first_bad].strb,
               w_log[first_bad].last, exp[first_bad].data, exp[first_bad].strb,
               exp[first_bad].last);
    end
    n_checks++;
    if (done_resp_o !== bresp_cfg || done_err_o !== 1'b0 || done_run_max != 1) begin
      n_fail++; $display("FAIL %s_done: resp=%0d err=%b width=%0d expected %0d 0 1",
                         tag, done_resp_o, done_err_o, done_run_max, bresp_cfg);
    end
    n_checks++;
    if (proto_viol != 0) begin
      n_fail++; $display("FAIL %s_protocol: %0d violations, expected 0", tag, proto_viol);
    end
  endtask

  // resp_mode: 0 all OKAY, 1 OKAY except SLVERR on beat len, 2 random
  task automatic test_read_burst(input logic [31:0] addr, input logic [7:0] len,
                                 input int last_cfg, input int resp_mode, input string tag);
    int exp_n, bad, first_bad, start;
    bit to, exp_err;
    logic [1:0] exp_resp;
    ar_log.delete(); rd_log.delete(); proto_viol = 0; done_run_max = 0;
    for (int i = 0; i < 300; i++) begin
      r_data_cfg[i] = $urandom;
      r_resp_cfg[i] = (resp_mode == 2) ? 2'($urandom_range(3)) :
                      (resp_mode == 1 && i == int'(len)) ? 2'b10 : 2'b00;
    end
    r_last_cfg = last_cfg;
    exp_n    = (last_cfg < 0) ? int'(len) + 1 : last_cfg + 1;
    exp_err  = (exp_n != int'(len) + 1);
    exp_resp = 2'b00;
    for (int i = 0; i < exp_n; i++) if (r_resp_cfg[i] > exp_resp) exp_resp = r_resp_cfg[i];
    start = done_count;
    issue_cmd(1'b0, addr, len);
    wait_done(start, exp_n * 40 + 500, to);
    r_last_cfg = -1;
    n_checks++;
    if (to) begin n_fail++; $display("FAIL %s_timeout: no done_o", tag); end
    n_checks++;
    if (ar_log.size() != 1) begin
      n_fail++; $display("FAIL %s_ar_count: %0d AR transfers, expected 1", tag, ar_log.size());
    end else if (ar_log[0].addr !== addr || ar_log[0].len !== len || ar_log[0].burst !== 2'b01) begin
      n_fail++; $display("FAIL %s_ar: addr=%h len=%0d burst=%0d expected %h %0d 1",
                         tag, ar_log[0].addr, ar_log[0].len, ar_log[0].burst, addr, len);
    end
    n_checks++;
    if (rd_log.size() != exp_n) begin
      n_fail++; $display("FAIL %s_rd_count: %0d beats, expected %0d", tag, rd_log.size(), exp_n);
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < exp_n && i < rd_log.size(); i++)
      if (rd_log[i].data !== r_data_cfg[i] || rd_log[i].last !== (i == exp_n - 1)) begin
        bad++; if (first_bad < 0) first_bad = i;
      end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL %s_rd_beats: %0d bad, first %0d got %h/%b expected %h/%b", tag,
                         bad, first_bad, rd_log[first_bad].data, rd_log[first_bad].last,
                         r_data_cfg[first_bad], first_bad == exp_n - 1);
    end
    n_checks++;
    if (done_resp_o !== exp_resp || done_err_o !== exp_err || done_run_max != 1) begin
      n_fail++; $display("FAIL %s_done: resp=%0d err=%b width=%0d expected %0d %b 1",
                         tag, done_resp_o, done_err_o, done_run_max, exp_resp, exp_err);
    end
  endtask

  task automatic test_reject(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                             input string tag);
    int aw0, ar0, start;
    bit to;
    aw0 = aw_valid_cycles; ar0 = ar_valid_cycles;
    start = done_count;
    issue_cmd(wr, addr, len);
    wait_done(start, 100, to);
    repeat (3) @(negedge ACLK);
    #1;
    n_checks++;
    if (to) begin n_fail++; $display("FAIL %s_timeout: no done_o", tag); end
    n_checks++;
    if (aw_valid_cycles != aw0 || ar_valid_cycles != ar0) begin
      n_fail++; $display("FAIL %s_traffic: aw/ar valid cycles +%0d/+%0d expected 0/0", tag,
                         aw_valid_cycles - aw0, ar_valid_cycles - ar0);
    end
    n_checks++;
    if (done_err_o !== 1'b1 || done_resp_o !== 2'b00) begin
      n_fail++; $display("FAIL %s_done: err=%b resp=%0d expected 1 0", tag, done_err_o, done_resp_o);
    end
  endtask

  task automatic test_long_write();
    aw_stall = 40; w_stall = 30; src_stall = 30;
    test_write_burst(32'h0000_2000, 8'd255, 1'b0, "wr_len255");
    aw_stall = 0; w_stall = 0; src_stall = 0;
  endtask

  task automatic test_reset_mid_burst();
    int start, guard;
    start = done_count;
    aw_log.delete(); w_log.delete();
    for (int i = 0; i < 8; i++) wr_q.push_back(beat_t'{$urandom, 4'hF, 1'b0});
    issue_cmd(1'b1, 32'h0000_0400, 8'd7);
    guard = 0;
    while (w_log.size() < 2 && guard < 200) begin @(negedge ACLK); #1; guard++; end
    @(negedge ACLK);
    ARSTN = 0;
    #1;
    n_checks++;
    if ({cmd_ready_o, wr_ready_o, rd_valid_o, done_o, M00_AXI_awvalid, M00_AXI_wvalid,
         M00_AXI_wlast, M00_AXI_bready, M00_AXI_arvalid, M00_AXI_rready} !== 10'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: valid/ready outputs not zero right after ARSTN low");
    end
    repeat (3) @(negedge ACLK);
    ARSTN = 1;
    repeat (4) @(negedge ACLK);
    #1;
    n_checks++;
    if (done_count != start) begin
      n_fail++; $display("FAIL rst_mid_done: %0d done pulses, expected 0", done_count - start);
    end
    bresp_cfg = 2'b00;
    test_write_burst(32'h0000_0800, 8'd5, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [7:0]  len;
    bit wr;
    for (int it = 0; it < 16; it++) begin
      wr  = $urandom_range(1);
      len = 8'($urandom_range(31));
      case ($urandom_range(5))
        0:       addr = 32'($urandom) | 32'h1;                  // misaligned
        1:       addr = {20'($urandom), 12'hFF0} & ~32'h3;      // near page end
        default: addr = {20'($urandom), 12'($urandom_range(255) * 4)};
      endcase
      aw_stall = $urandom_range(50); w_stall = $urandom_range(50);
      ar_stall = $urandom_range(50); src_stall = $urandom_range(50);
      rd_mode  = 2;
      bresp_cfg = 2'($urandom_range(3));
      if (ref_reject(addr, len)) test_reject(wr, addr, len, "rnd_rej");
      else if (wr) test_write_burst(addr, len, 1'b0, "rnd_wr");
      else test_read_burst(addr, len, ($urandom_range(3) == 0) ? int'(len) + 2 : -1, 2, "rnd_rd");
    end
    aw_stall = 0; w_stall = 0; ar_stall = 0; src_stall = 0; rd_mode = 0;
  endtask

  initial begin
    test_reset();
    bresp_cfg = 2'b00;
    test_write_burst(32'h0000_0100, 8'd3, 1'b1, "wr_basic");
    rd_mode = 1;
    test_read_burst(32'h0000_0200, 8'd7, -1, 1, "rd_toggle");
    rd_mode = 0;
    test_reject(1'b1, 32'h0000_0FF8, 8'd3, "rej_4k");
    test_reject(1'b0, 32'h0000_0102, 8'd0, "rej_align");
    test_write_burst(32'h0000_0FF0, 8'd3, 1'b0, "wr_page_end");
    test_read_burst(32'h0000_0300, 8'd3, 1, 0, "rd_early_last");
    test_read_burst(32'h0000_0340, 8'd3, 5, 0, "rd_late_last");
    test_long_write();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
